// File: rtl/tiger_divider_if.sv
// tiger_divider_if: request/result bundle between the execute-stage pipeline and the divider.
// Signals: start (1-cycle request), abort (flush), is_signed (DIV vs DIVU),
//          dividend/divisor (operands), busy, done (result pulse), quotient (LO), remainder (HI).
// Modports: master = pipeline side, slave = divider side.
interface tiger_divider_if #(parameter int WIDTH = 32);
    logic             start;
    logic             abort;
    logic             is_signed;
    logic [WIDTH-1:0] dividend;
    logic [WIDTH-1:0] divisor;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] quotient;
    logic [WIDTH-1:0] remainder;
    modport master (output start, abort, is_signed, dividend, divisor,
                    input  busy, done, quotient, remainder);
    modport slave  (input  start, abort, is_signed, dividend, divisor,
                    output busy, done, quotient, remainder);
endinterface

// File: rtl/tiger_divider.sv
// tiger_divider: iterative radix-2 restoring divider (DIV/DIVU) producing LO (quotient) and HI (remainder).
// Ports: clk, reset_n (async, active-low), bus (tiger_divider_if.slave: start, abort, is_signed,
//        dividend, divisor in; busy, done, quotient, remainder out, all registered).
// Option: define TIGER_DIV_ZERO_FAST_EN to skip the iterations for a zero divisor.
module tiger_divider #(
    parameter int WIDTH = 32
) (
    input logic          clk,
    input logic          reset_n,
    tiger_divider_if.slave bus
);
    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    typedef enum logic [1:0] {IDLE, RUN, FIX, DONE} state_t;

    state_t           state, state_nx;
    logic [WIDTH-1:0] acc;
    logic [WIDTH-1:0] rem;
    logic [WIDTH-1:0] den;
    logic [CW-1:0]    cnt;
    logic             neg_q, neg_r, fast, fast_nx, busy_nx, done_nx;
    logic             accept, zero_fast, ge;
    logic [WIDTH-1:0] abs_a, abs_b, low;

    assign accept = (state == IDLE) && bus.start && !bus.abort;
    assign abs_a  = (bus.is_signed && bus.dividend[WIDTH-1]) ? -bus.dividend : bus.dividend;
    assign abs_b  = (bus.is_signed && bus.divisor[WIDTH-1])  ? -bus.divisor  : bus.divisor;

`ifdef TIGER_DIV_ZERO_FAST_EN
    assign zero_fast = (bus.divisor == '0);
`else
    assign zero_fast = 1'b0;
`endif

    // Trial subtraction on the shifted partial remainder; the borrow is resolved by the
    // WIDTH+1-bit compare, so the low WIDTH bits of the difference are always exact.
    assign low = {rem[WIDTH-2:0], acc[WIDTH-1]};
    assign ge  = {rem, acc[WIDTH-1]} >= {1'b0, den};

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) state <= IDLE;
        else          state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        if (bus.abort) state_nx = IDLE;
        else begin
            case (state)
                IDLE:    if (bus.start) state_nx = zero_fast ? FIX : RUN;
                RUN:     if (cnt == '0) state_nx = FIX;
                FIX:     state_nx = DONE;
                default: state_nx = IDLE;
            endcase
        end
    end

    // The zero-divisor shortcut keeps busy low until the single done cycle.
    always_comb begin
        fast_nx = accept ? zero_fast : fast;
        done_nx = !bus.abort && (state == DONE);
        busy_nx = done_nx || ((state_nx != IDLE) && !fast_nx);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            bus.busy      <= 1'b0;
            bus.done      <= 1'b0;
            bus.quotient  <= '0;
            bus.remainder <= '0;
            fast          <= 1'b0;
        end else begin
            bus.busy <= busy_nx;
            bus.done <= done_nx;
            fast     <= fast_nx;
            if (done_nx) begin
                bus.quotient  <= acc;
                bus.remainder <= rem;
            end
        end
    end

    // A zero divisor preloads what the full iteration would leave: all-ones quotient bits
    // and the dividend magnitude as remainder; FIX then applies the usual sign rules.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            acc   <= '0;
            rem   <= '0;
            den   <= '0;
            cnt   <= '0;
            neg_q <= 1'b0;
            neg_r <= 1'b0;
        end else if (accept) begin
            acc   <= zero_fast ? '1 : abs_a;
            rem   <= zero_fast ? abs_a : '0;
            den   <= abs_b;
            cnt   <= CW'(WIDTH - 1);
            neg_q <= bus.is_signed && (bus.dividend[WIDTH-1] ^ bus.divisor[WIDTH-1]);
            neg_r <= bus.is_signed && bus.dividend[WIDTH-1];
        end else if (state == RUN) begin
            rem <= ge ? low - den : low;
            acc <= {acc[WIDTH-2:0], ge};
            cnt <= cnt - CW'(1);
        end else if (state == FIX) begin
            acc <= neg_q ? -acc : acc;
            rem <= neg_r ? -rem : rem;
        end
    end
endmodule

// File: doc/tiger_divider.md
# tiger_divider

Iterative radix-2 restoring divider for the Tiger MIPS core. It executes DIV/DIVU, the multi-cycle counterpart of the single-cycle ALU add/sub/compare path, and writes the HI/LO results. It sits beside the ALU in the execute stage. The pipeline starts it with a one-cycle `start` pulse, stalls on `busy`, and collects the quotient (LO) and remainder (HI) when `done` pulses.

## Interface
- `WIDTH`, default 32: operand and result width. Fixed at 32 in the Tiger core; the bench also runs 8.
- `clk`  input  1  system clock; all state changes on the rising edge.
- `reset_n`  input  1  asynchronous, active-low reset.
- `start`  input  1  one-cycle request; sampled only in IDLE.
- `abort`  input  1  pipeline flush; cancels any operation in flight.
- `is_signed`  input  1  1 = DIV (two's complement), 0 = DIVU.
- `dividend`  input  WIDTH  numerator; sampled with `start`.
- `divisor`  input  WIDTH  denominator; sampled with `start`.
- `busy`  output  1  high from the cycle after an accepted `start` until `done`, inclusive.
- `done`  output  1  one-cycle pulse; results are valid from this cycle.
- `quotient`  output  WIDTH  LO result; holds until the next `done`.
- `remainder`  output  WIDTH  HI result; holds until the next `done`.

## Operation
- Four states, IDLE, RUN, FIX and DONE, with these transitions:
  - IDLE goes to RUN on `start` (when `abort` is low).
  - RUN goes to FIX after WIDTH iterations.
  - FIX goes to DONE.
  - DONE returns to IDLE unconditionally.
- Accepting `start`:
  - Latch |dividend| and |divisor|. Magnitudes are taken only when `is_signed`=1.
  - Latch the sign flags: quotient is negated if the operand signs differ; remainder takes the sign of the dividend.
  - Clear the partial remainder and load the iteration counter with WIDTH-1.
- Each RUN cycle:
  - Shift {partial remainder, dividend register} left by one.
  - Compute trial = partial remainder − |divisor| in WIDTH+1 bits.
  - If the trial is non-negative, commit it and shift in a quotient bit of 1; otherwise shift in 0.
- FIX: apply the sign corrections (two's-complement negate), then register the results to `quotient` and `remainder`.
- Magnitude rule: |0x80000000| is taken as unsigned 0x80000000, with no saturation.
- Signed overflow: −2^31 / −1 gives quotient 0x80000000, remainder 0.
- Divide by zero returns exactly what the raw restoring algorithm produces:
  - Unsigned: quotient all-ones, remainder = dividend.
  - Signed, dividend negative: quotient 1, remainder = dividend.
  - Signed, dividend non-negative: quotient all-ones, remainder = dividend.
- `start` in any state other than IDLE is ignored. It is not queued.
- `abort` in any state forces IDLE on the next edge. No `done` is produced and `quotient`/`remainder` keep their previous values.
- `abort` and `start` together in IDLE: `abort` wins and the request is dropped.
- Reset (asynchronous, at any time, including mid-operation):
  - State goes to IDLE.
  - `busy`=0, `done`=0, `quotient`=0, `remainder`=0.
  - All internal registers are cleared.

## Timing
- Cycle numbering: `start` is sampled at edge 0.
- Edges 1…WIDTH are the RUN iterations; edge WIDTH+1 is FIX.
- `done` is high in the cycle after edge WIDTH+2, i.e. WIDTH+2 edges after `start` (34 for WIDTH=32).
- `busy` is high from edge 1 through the `done` cycle.
- `busy` falls in the same cycle that `done` falls, so a new `start` is accepted in the first cycle after `done`.
- Back-to-back throughput: one result per WIDTH+3 cycles.
- All outputs are registered, with no combinational input-to-output path.

## Configuration
- Macro `TIGER_DIV_ZERO_FAST_EN`.
- Defined:
  - A divisor of zero at `start` skips RUN and goes straight to FIX, which loads the divide-by-zero results listed above.
  - `done` is high 2 edges after `start`; `busy` is high for exactly that `done` cycle.
- Undefined:
  - A zero divisor runs the full WIDTH+2 latency.
  - Results are bit-identical to the defined build.
- Every other behaviour is unchanged.

## Test plan
- Unsigned 100 / 7, `is_signed`=0 → `done` at edge 34, quotient 14, remainder 2; `busy` high for edges 1–34.
- Signed −7 / 2 (0xFFFFFFF9, 2) → quotient 0xFFFFFFFD (−3), remainder 0xFFFFFFFF (−1); then 7 / −2 → quotient −3, remainder 1.
- Signed 0x80000000 / 0xFFFFFFFF → quotient 0x80000000, remainder 0. Unsigned 0xFFFFFFFF / 1 → quotient 0xFFFFFFFF, remainder 0.
- Divide by zero:
  - Stimulus: DIVU 5 / 0 and DIV −5 / 0.
  - Results: quotient 0xFFFFFFFF, remainder 5; then quotient 1, remainder 0xFFFFFFFB.
  - Latency: 34 edges without the macro, 2 with `TIGER_DIV_ZERO_FAST_EN`.
- Control boundaries:
  - `abort` at edge 10 of an operation → idle at edge 11, no `done`, outputs unchanged.
  - `start` pulsed at edge 5 while busy → ignored.
  - `start` together with `abort` in IDLE → dropped.
  - `reset_n` low mid-RUN → all outputs 0 immediately, without waiting for a clock edge.
- Randomized back-to-back starts issued the cycle after each `done`, checked against a reference model. Cover signed and unsigned, WIDTH=32 and WIDTH=8.
